// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and default address map for the memory-stage bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10,
        SzIll  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        SelDm = 2'd0,
        SelT1 = 2'd1,
        SelT2 = 2'd2
    } sel_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp,
        StFault
    } state_e;

    localparam logic [31:0] DefDmEnd     = 32'h0000_2FFF;
    localparam logic [31:0] DefT1Base    = 32'h0000_7F00;
    localparam logic [31:0] DefT2Base    = 32'h0000_7F10;
    localparam int unsigned DefTimeout   = 16;

    localparam logic [31:0] TimerWinLast = 32'd11;
    // Timer count register is read-only.
    localparam logic [31:0] TimerCntOff  = 32'd8;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational address decode: slave select, byte enables, lane-replicated store data
// and fault flag for one memory access.
module mem_addr_check
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] DM_END  = DefDmEnd,
    parameter logic [31:0] T1_BASE = DefT1Base,
    parameter logic [31:0] T2_BASE = DefT2Base
) (
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [1:0]  sel_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] word_addr_o,
    output logic        fault_o
);

    logic [31:0] t1_off;
    logic [31:0] t2_off;
    logic        in_dm;
    logic        in_t1;
    logic        in_t2;
    logic        is_word;
    logic        misaligned;
    logic        ro_store;

    always_comb begin
        t1_off     = addr_i - T1_BASE;
        t2_off     = addr_i - T2_BASE;
        in_dm      = addr_i <= DM_END;
        in_t1      = (addr_i >= T1_BASE) && (t1_off <= TimerWinLast);
        in_t2      = (addr_i >= T2_BASE) && (t2_off <= TimerWinLast);
        is_word    = (size_i == SzWord) || (size_i == SzIll);
        misaligned = 1'b0;
        unique case (size_i)
            SzByte:  misaligned = 1'b0;
            SzHalf:  misaligned = addr_i[0];
            default: misaligned = |addr_i[1:0];
        endcase
        ro_store = we_i && ((in_t1 && t1_off == TimerCntOff) || (in_t2 && t2_off == TimerCntOff));
        fault_o  = misaligned || !(in_dm || in_t1 || in_t2)
                   || ((in_t1 || in_t2) && !is_word) || ro_store;

        if (in_t1) begin
            sel_o = SelT1;
        end else if (in_t2) begin
            sel_o = SelT2;
        end else begin
            sel_o = SelDm;
        end

        be_o    = 4'b1111;
        wdata_o = wdata_i;
        if (we_i && !is_word) begin
            if (size_i == SzByte) begin
                be_o    = 4'b0001 << addr_i[1:0];
                wdata_o = {4{wdata_i[7:0]}};
            end else begin
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
        end

        word_addr_o = {addr_i[31:2], 2'b00};
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus controller: round-robin grant, address check, single outstanding
// slave transaction with timeout, done/exception pulse back to the winner.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] DM_END  = DefDmEnd,
    parameter logic [31:0] T1_BASE = DefT1Base,
    parameter logic [31:0] T2_BASE = DefT2Base,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [1:0]  c_size,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic        c_done,
    output logic        c_exc,
    output logic        c_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_exc,
    output logic [1:0]  s_sel,
    output logic        s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [3:0]  s_be,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ready
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            last_is_d_q, last_is_d_d;
    logic            win_is_d_q, win_is_d_d;
    logic            we_q, we_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        d_wins;
    logic        m_we;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  chk_sel;
    logic [3:0]  chk_be;
    logic [31:0] chk_wdata;
    logic [31:0] chk_addr;
    logic        chk_fault;

    // On a tie the requester that did not win last time goes next.
    assign d_wins  = d_req && (!c_req || !last_is_d_q);
    assign m_we    = d_wins ? d_we    : c_we;
    assign m_size  = d_wins ? d_size  : c_size;
    assign m_addr  = d_wins ? d_addr  : c_addr;
    assign m_wdata = d_wins ? d_wdata : c_wdata;

    mem_addr_check #(
        .DM_END  (DM_END),
        .T1_BASE (T1_BASE),
        .T2_BASE (T2_BASE)
    ) u_addr_check (
        .we_i        (m_we),
        .size_i      (m_size),
        .addr_i      (m_addr),
        .wdata_i     (m_wdata),
        .sel_o       (chk_sel),
        .be_o        (chk_be),
        .wdata_o     (chk_wdata),
        .word_addr_o (chk_addr),
        .fault_o     (chk_fault)
    );

    always_comb begin
        state_d     = state_q;
        last_is_d_d = last_is_d_q;
        win_is_d_d  = win_is_d_q;
        we_d        = we_q;
        sel_d       = sel_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (c_req || d_req) begin
                    win_is_d_d  = d_wins;
                    last_is_d_d = d_wins;
                    we_d        = m_we;
                    sel_d       = chk_sel;
                    be_d        = chk_be;
                    wdata_d     = chk_wdata;
                    addr_d      = chk_addr;
                    cnt_d       = '0;
                    state_d     = chk_fault ? StFault : StIssue;
                end
            end
            StIssue: begin
                if (s_ready) begin
                    rdata_d = s_rdata;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp:  state_d = StIdle;
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            last_is_d_q <= 1'b1;
            win_is_d_q  <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 2'd0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            addr_q      <= 32'd0;
            rdata_q     <= 32'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_is_d_q <= last_is_d_d;
            win_is_d_q  <= win_is_d_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    logic st_issue;
    logic st_resp;
    logic st_fault;

    always_comb begin
        st_issue = state_q == StIssue;
        st_resp  = state_q == StResp;
        st_fault = state_q == StFault;

        s_req   = st_issue;
        s_we    = st_issue && we_q;
        s_be    = st_issue ? be_q : 4'd0;
        s_sel   = sel_q;
        s_addr  = addr_q;
        s_wdata = wdata_q;

        c_done  = (st_resp || st_fault) && !win_is_d_q;
        c_exc   = st_fault && !win_is_d_q;
        c_rdata = (st_resp && !win_is_d_q) ? rdata_q : 32'd0;
        d_done  = (st_resp || st_fault) && win_is_d_q;
        d_exc   = st_fault && win_is_d_q;
        d_rdata = (st_resp && win_is_d_q) ? rdata_q : 32'd0;
        c_stall = c_req && !c_done;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, arbitration/reset
// sequences and randomized transactions against a rule-level reference model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [1:0]  c_size, d_size;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [31:0] c_rdata, d_rdata;
    logic        c_done, c_exc, c_stall, d_done, d_exc;
    logic [1:0]  s_sel;
    logic        s_req, s_we, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_size  (c_size),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_rdata (c_rdata),
        .c_done  (c_done),
        .c_exc   (c_exc),
        .c_stall (c_stall),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_size  (d_size),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_done  (d_done),
        .d_exc   (d_exc),
        .s_sel   (s_sel),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_be    (s_be),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Results of the most recent run, indexed by port (0 = CPU, 1 = debug).
    int          lat[2];
    logic        exc_r[2];
    logic [31:0] rd_r[2];
    int          icnt_r[2];
    logic [1:0]  sn_sel[2];
    logic [3:0]  sn_be[2];
    logic [31:0] sn_wd[2];
    logic [31:0] sn_addr[2];
    logic        sn_we[2];
    int          order[$];
    bit          stall_bad;
    bit          nonwin_bad;

    // Plays the slave until every raised request has seen its done pulse.
    task automatic run(input int delay, input logic [31:0] rdv, input bit noise);
        int          cyc = 0;
        int          icnt = 0;
        logic [1:0]  t_sel = 0;
        logic [3:0]  t_be = 0;
        logic [31:0] t_wd = 0;
        logic [31:0] t_addr = 0;
        logic        t_we = 0;
        order.delete();
        stall_bad  = 0;
        nonwin_bad = 0;
        for (int p = 0; p < 2; p++) begin
            lat[p] = -1; exc_r[p] = 0; rd_r[p] = 0; icnt_r[p] = 0;
        end
        while ((c_req || d_req) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (c_stall !== (c_req & ~c_done)) stall_bad = 1;
            if (c_done && d_done) nonwin_bad = 1;
            if (!c_done && (c_exc || c_rdata != 0)) nonwin_bad = 1;
            if (!d_done && (d_exc || d_rdata != 0)) nonwin_bad = 1;
            if (s_req) begin
                if (icnt == 0) begin
                    t_sel = s_sel; t_be = s_be; t_wd = s_wdata; t_addr = s_addr; t_we = s_we;
                end
                s_ready = (icnt == delay);
                s_rdata = (icnt == delay) ? rdv : $urandom;
                icnt++;
            end else begin
                s_ready = noise && ($urandom_range(0, 1) == 1);
                s_rdata = $urandom;
            end
            if (c_done || d_done) begin
                int p = d_done ? 1 : 0;
                lat[p]     = cyc;
                exc_r[p]   = p ? d_exc : c_exc;
                rd_r[p]    = p ? d_rdata : c_rdata;
                icnt_r[p]  = icnt;
                sn_sel[p]  = t_sel; sn_be[p] = t_be; sn_wd[p] = t_wd;
                sn_addr[p] = t_addr; sn_we[p] = t_we;
                order.push_back(p);
                if (p == 1) d_req = 0; else c_req = 0;
                icnt = 0;
            end
        end
        if (c_req || d_req) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_bound: requests still pending after %0d cycles", cyc);
        end
        c_req = 0; d_req = 0; s_ready = 0;
    endtask

    task automatic drive(input int p, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 1) begin
            d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        end else begin
            c_req = 1; c_we = we; c_size = sz; c_addr = a; c_wdata = wd;
        end
    endtask

    task automatic issue1(input int p, input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int delay, input logic [31:0] rdv,
                          input bit noise);
        @(negedge clk);
        drive(p, we, sz, a, wd);
        run(delay, rdv, noise);
    endtask

    // Reference model: access rules stated directly on byte counts and address ranges.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int region(input logic [31:0] a);
        if (a <= 32'h2FFF) return 0;
        if (a >= 32'h7F00 && a < 32'h7F0C) return 1;
        if (a >= 32'h7F10 && a < 32'h7F1C) return 2;
        return -1;
    endfunction

    function automatic bit ref_fault(input logic we, input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        int r = region(a);
        if (a % n != 0) return 1;
        if (r < 0) return 1;
        if (r > 0 && n != 4) return 1;
        if (r > 0 && we && (a - (r == 1 ? 32'h7F00 : 32'h7F10)) == 8) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic we, input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        if (!we || n == 4) return 4'hF;
        if (n == 1) return 4'(1 << (a % 4));
        return 4'(3 << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wd(input logic [1:0] sz, input logic [31:0] wd);
        int n = nbytes(sz);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic check_txn(input int p, input logic we, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd, input int delay,
                             input logic [31:0] rdv);
        bit f  = ref_fault(we, sz, a);
        bit to = !f && delay >= 16;
        chk("rnd.lat", lat[p], f ? 1 : (to ? 17 : 2 + delay));
        chk("rnd.exc", {31'd0, exc_r[p]}, {31'd0, f || to});
        chk("rnd.issue_cycles", icnt_r[p], f ? 0 : (to ? 16 : delay + 1));
        chk("rnd.stall", {31'd0, stall_bad}, 0);
        chk("rnd.nonwinner", {31'd0, nonwin_bad}, 0);
        if (!f && !to) begin
            chk("rnd.rdata", rd_r[p], rdv);
            chk("rnd.sel", {30'd0, sn_sel[p]}, region(a));
            chk("rnd.be", {28'd0, sn_be[p]}, {28'd0, ref_be(we, sz, a)});
            chk("rnd.addr", sn_addr[p], a - (a % 4));
            chk("rnd.we", {31'd0, sn_we[p]}, {31'd0, we});
            if (we) chk("rnd.wdata", sn_wd[p], ref_wd(sz, wd));
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return $urandom_range(0, 32'h2FFF);
            1:       return 32'h7F00 + $urandom_range(0, 15);
            2:       return 32'h7F10 + $urandom_range(0, 15);
            3:       return 32'h2FF8 + $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        int          p;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        int          dly;
        logic        exc;
        int          lat;
        logic [1:0]  sel;
        logic [3:0]  be;
        logic [31:0] swd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] rdv;
        reset = 0; c_req = 0; d_req = 0; c_we = 0; d_we = 0; c_size = 0; d_size = 0;
        c_addr = 0; d_addr = 0; c_wdata = 0; d_wdata = 0; s_ready = 0; s_rdata = 0;

        tbl.push_back('{0, 0, 2'd2, 32'h0000_0010, 32'h0,        0,  0, 2,  2'd0, 4'hF, 32'h0});
        tbl.push_back('{0, 1, 2'd0, 32'h0000_0003, 32'hAB,       0,  0, 2,  2'd0, 4'h8, 32'hABABABAB});
        tbl.push_back('{0, 0, 2'd1, 32'h0000_0001, 32'h0,        0,  1, 1,  2'd0, 4'h0, 32'h0});
        tbl.push_back('{0, 0, 2'd0, 32'h0000_7F00, 32'h0,        0,  1, 1,  2'd0, 4'h0, 32'h0});
        tbl.push_back('{0, 1, 2'd2, 32'h0000_7F08, 32'h1,        0,  1, 1,  2'd0, 4'h0, 32'h0});
        tbl.push_back('{1, 1, 2'd1, 32'h0000_2FFE, 32'h1234,     3,  0, 5,  2'd0, 4'hC, 32'h12341234});
        tbl.push_back('{1, 0, 2'd2, 32'h0000_3000, 32'h0,        0,  1, 1,  2'd0, 4'h0, 32'h0});
        tbl.push_back('{0, 1, 2'd2, 32'h0000_7F14, 32'hDEADBEEF, 1,  0, 3,  2'd2, 4'hF, 32'hDEADBEEF});
        tbl.push_back('{1, 0, 2'd2, 32'h0000_7F18, 32'h0,        0,  0, 2,  2'd2, 4'hF, 32'h0});
        tbl.push_back('{0, 0, 2'd2, 32'h0000_7F0C, 32'h0,        0,  1, 1,  2'd0, 4'h0, 32'h0});
        tbl.push_back('{0, 0, 2'd2, 32'h0000_7F08, 32'h0,        2,  0, 4,  2'd1, 4'hF, 32'h0});
        tbl.push_back('{0, 1, 2'd3, 32'h0000_0004, 32'h11223344, 0,  0, 2,  2'd0, 4'hF, 32'h11223344});
        tbl.push_back('{0, 0, 2'd2, 32'h0000_0020, 32'h0,        16, 1, 17, 2'd0, 4'h0, 32'h0});
        tbl.push_back('{0, 0, 2'd2, 32'h0000_0024, 32'h0,        15, 0, 17, 2'd0, 4'hF, 32'h0});
        tbl.push_back('{1, 1, 2'd0, 32'h0000_2FFF, 32'h5A,       0,  0, 2,  2'd0, 4'h8, 32'h5A5A5A5A});
        tbl.push_back('{0, 0, 2'd2, 32'hFFFF_FFFC, 32'h0,        0,  1, 1,  2'd0, 4'h0, 32'h0});
        tbl.push_back('{0, 1, 2'd2, 32'h0000_7F10, 32'hCAFE,     0,  0, 2,  2'd2, 4'hF, 32'hCAFE});
        tbl.push_back('{1, 1, 2'd1, 32'h0000_0102, 32'hBEEF,     0,  0, 2,  2'd0, 4'hC, 32'hBEEFBEEF});

        #12;
        chk("rst.s_req", {31'd0, s_req}, 0);
        chk("rst.s_we", {31'd0, s_we}, 0);
        chk("rst.s_be", {28'd0, s_be}, 0);
        chk("rst.done", {30'd0, c_done, d_done}, 0);
        chk("rst.exc", {30'd0, c_exc, d_exc}, 0);
        chk("rst.rdata", c_rdata | d_rdata, 0);
        @(negedge clk);
        reset = 1;

        // Tie straight out of reset: CPU first, then the held debug request.
        @(negedge clk);
        drive(0, 0, 2'd2, 32'h100, 0);
        drive(1, 0, 2'd2, 32'h7F04, 0);
        run(0, 32'h5555_AAAA, 0);
        chk("tie1.count", order.size(), 2);
        chk("tie1.first", (order.size() > 0) ? order[0] : 9, 0);
        chk("tie1.c_lat", lat[0], 2);
        chk("tie1.d_lat", lat[1], 5);
        chk("tie1.d_rdata", rd_r[1], 32'h5555_AAAA);
        chk("tie1.nonwinner", {31'd0, nonwin_bad}, 0);

        @(negedge clk);
        drive(0, 0, 2'd2, 32'h104, 0);
        drive(1, 0, 2'd2, 32'h108, 0);
        run(0, 32'h1, 0);
        chk("tie2.first", (order.size() > 0) ? order[0] : 9, 0);

        // Lone CPU grant makes the next tie go to the debug port.
        issue1(0, 0, 2'd2, 32'h10C, 0, 0, 32'h2, 0);
        @(negedge clk);
        drive(0, 0, 2'd2, 32'h110, 0);
        drive(1, 0, 2'd2, 32'h114, 0);
        run(0, 32'h3, 0);
        chk("tie3.first", (order.size() > 0) ? order[0] : 9, 1);
        chk("tie3.c_lat", lat[0], 5);

        foreach (tbl[i]) begin
            rdv = $urandom;
            issue1(tbl[i].p, tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].dly, rdv, 0);
            chk($sformatf("vec%0d.lat", i), lat[tbl[i].p], tbl[i].lat);
            chk($sformatf("vec%0d.exc", i), {31'd0, exc_r[tbl[i].p]}, {31'd0, tbl[i].exc});
            chk($sformatf("vec%0d.issue", i), icnt_r[tbl[i].p],
                tbl[i].exc ? ((tbl[i].dly >= 16) ? 16 : 0) : tbl[i].dly + 1);
            chk($sformatf("vec%0d.stall", i), {31'd0, stall_bad}, 0);
            if (!tbl[i].exc) begin
                chk($sformatf("vec%0d.sel", i), {30'd0, sn_sel[tbl[i].p]}, {30'd0, tbl[i].sel});
                chk($sformatf("vec%0d.be", i), {28'd0, sn_be[tbl[i].p]}, {28'd0, tbl[i].be});
                chk($sformatf("vec%0d.rdata", i), rd_r[tbl[i].p], rdv);
                chk($sformatf("vec%0d.we", i), {31'd0, sn_we[tbl[i].p]}, {31'd0, tbl[i].we});
                if (tbl[i].we) chk($sformatf("vec%0d.wdata", i), sn_wd[tbl[i].p], tbl[i].swd);
            end
        end

        // Reset during ISSUE drops the slave request at once and loses the transaction.
        @(negedge clk);
        drive(0, 0, 2'd2, 32'h40, 0);
        @(negedge clk);
        chk("rstmid.issue", {31'd0, s_req}, 1);
        #2 reset = 0;
        #1;
        chk("rstmid.s_req", {31'd0, s_req}, 0);
        chk("rstmid.done", {31'd0, c_done}, 0);
        @(negedge clk);
        chk("rstmid.done_late", {31'd0, c_done}, 0);
        c_req = 0;
        @(negedge clk);
        reset = 1;
        issue1(0, 0, 2'd2, 32'h44, 0, 0, 32'h0BAD_F00D, 0);
        chk("rstmid.after_lat", lat[0], 2);
        chk("rstmid.after_rdata", rd_r[0], 32'h0BAD_F00D);

        for (int k = 0; k < 80; k++) begin
            int          p   = $urandom_range(0, 1);
            logic        we  = ($urandom_range(0, 1) == 1);
            logic [1:0]  sz  = 2'($urandom_range(0, 3));
            logic [31:0] a   = rand_addr();
            logic [31:0] wd  = $urandom;
            int          dly = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 3);
            logic [31:0] rv  = $urandom;
            issue1(p, we, sz, a, wd, dly, rv, 1);
            check_txn(p, we, sz, a, wd, dly, rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Memory-stage bus controller for the pipelined CPU.
- Arbitrates between two requesters: CPU M stage (c_*) and debug/DMA port (d_*).
- Decodes addresses onto the shared slave bus (DM, Timer1, Timer2) and checks alignment, range and timer-access rules.
- Sequences one outstanding transaction at a time through a variable-latency ready handshake; drives the CPU stall.

Parameters:
DM_END, 32'h0000_2FFF, last valid DM byte address (DM spans 0..DM_END)
T1_BASE, 32'h0000_7F00, Timer1 base; 12-byte window (3 word registers)
T2_BASE, 32'h0000_7F10, Timer2 base; 12-byte window
TIMEOUT, 16, max cycles in ISSUE waiting for s_ready before abort

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
c_req  in  1  CPU request; held until c_done
c_we  in  1  1=store, 0=load
c_size  in  2  00 byte, 01 half, 10 word (11 = illegal, treated as word)
c_addr  in  32  byte address
c_wdata  in  32  store data, right-aligned
c_rdata  out  32  raw word read from slave (lane extraction done downstream)
c_done  out  1  one-cycle completion pulse
c_exc  out  1  valid with c_done: 1 = AdEL (load) / AdES (store)
c_stall  out  1  c_req & ~c_done
d_req, d_we, d_size, d_addr, d_wdata, d_rdata, d_done, d_exc  same as c_* for debug port
s_sel  out  2  0 DM, 1 Timer1, 2 Timer2
s_req  out  1  slave request
s_we  out  1  slave write
s_addr  out  32  word-aligned address (low 2 bits zero)
s_be  out  4  byte enables
s_wdata  out  32  lane-shifted store data
s_rdata  in  32  slave read data, valid with s_ready
s_ready  in  1  slave completion

Behaviour:
- Reset (reset=0, async): state IDLE; s_req, s_we, c_done, d_done, c_exc, d_exc = 0; rdata regs = 0; s_be = 0; last_grant = D (CPU wins first tie); timeout counter = 0.
- States and transitions:
  - IDLE: if any req, grant and latch winner's we/size/addr/wdata. Evaluate fault on the latched values: go to FAULT if faulting, else ISSUE.
  - ISSUE: s_req=1 with decoded s_sel/s_be/s_wdata/s_addr held stable. On s_ready: latch s_rdata and go to RESP. If counter reaches TIMEOUT-1 without s_ready: drop s_req and go to FAULT.
  - RESP: winner's done=1, exc=0, rdata valid; then IDLE.
  - FAULT: winner's done=1, exc=1; no slave write occurs; then IDLE.
- Arbitration:
  - Only one requester active: that one wins.
  - Both active: the requester not in last_grant wins (round robin).
  - last_grant updates on every grant.
- Latency: minimum 3 cycles from req sampled in IDLE to done (IDLE, ISSUE with s_ready=1, RESP). A fault returns done 2 cycles after sampling.
- Requester handshake: requester deasserts req on the edge ending its done cycle. A req still high in the following IDLE is a new transaction.
- Fault conditions, any of:
  - misaligned: word with addr[1:0]!=0, or half with addr[0]!=0
  - address outside DM, Timer1 and Timer2 windows
  - timer access with size != word
  - store to timer offset 8 (count register is read-only)
  - timeout
- Lane rules:
  - Byte: s_be = 1<<addr[1:0], data replicated 4x.
  - Half: s_be = addr[1] ? 1100 : 0011, data replicated 2x.
  - Word: s_be = 1111.
  - Loads: s_be = 1111.
- Arithmetic: range compares are 32-bit unsigned; window end = base+11 inclusive.
- s_ready outside ISSUE is ignored. Non-winner outputs stay 0 throughout.
- Reset mid-transaction: s_req drops immediately; the transaction is lost; no done is issued.

Decomposition:
- Shared package/header: size codes, s_sel codes, FSM state encodings, default address-map constants.
- One natural sub-module, mem_addr_check: combinational decode to s_sel, s_be, shifted wdata and fault flag. It is reusable by the store-side checker.

Test Plan:
- CPU lw 0x0000_0010, s_ready in first ISSUE cycle -> s_be=1111, s_sel=0, c_done pulse 3 cycles after req, c_rdata = s_rdata, c_exc=0.
- CPU sb 0x0000_0003, wdata 0x000000AB -> s_be=1000, s_wdata=0xABABABAB, s_we=1, c_done, c_exc=0.
- CPU lh 0x0000_0001 -> no s_req, c_done+c_exc 2 cycles after req; same for lb 0x7F00 (timer non-word) and sw 0x7F08.
- c_req and d_req both raised the cycle after reset -> CPU granted first; after c_done, the held d_req is granted; next tie goes to CPU.
- s_ready held 0 -> s_req drops after 16 ISSUE cycles, c_done with c_exc=1; c_stall high for the whole wait.
- reset asserted during ISSUE -> s_req=0 the same cycle; no done; after release, a fresh lw completes normally.
